// File: rtl/sienna_pkg.sv
// Shared types and constants for the sienna MAC / activation / pool / dropout pipeline.
package sienna_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MAC  = 3'd1,
        ST_ACT  = 3'd2,
        ST_POOL = 3'd3,
        ST_DROP = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic [1:0] ACT_IDENTITY = 2'b00;
    localparam logic [1:0] ACT_RELU     = 2'b01;
    localparam logic [1:0] ACT_LEAKY    = 2'b10;
    localparam logic [1:0] ACT_SAT      = 2'b11;

    localparam logic [31:0] LFSR_SEED = 32'hACE1ACE1;
    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    // One right-shifting Galois step: feed the polynomial back when bit 0 falls out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ({1'b0, v[31:1]} ^ LFSR_POLY) : {1'b0, v[31:1]};
    endfunction

endpackage

// File: rtl/sienna_fifo.sv
// Synchronous FIFO between the MAC stage and the activation stage.
// The count output is the low bits of the fill level, so it reads 0 when full.
module sienna_fifo
    import sienna_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2048
)(
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push_i,
    input  logic [DATA_WIDTH-1:0]         push_data_i,
    input  logic                          pop_i,
    output logic [DATA_WIDTH-1:0]         pop_data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(DEPTH)-1:0]      count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [AW:0]           fill_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    assign full_o     = (fill_r == (AW+1)'(DEPTH));
    assign empty_o    = (fill_r == '0);
    assign count_o    = fill_r[AW-1:0];
    assign do_push_s  = push_i && !full_o;
    assign do_pop_s   = pop_i && !empty_o;
    assign pop_data_o = empty_o ? '0 : mem[rd_ptr_r];

    // Pointer and fill-level bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            fill_r   <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= (wr_ptr_r == AW'(DEPTH - 1)) ? '0 : wr_ptr_r + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= (rd_ptr_r == AW'(DEPTH - 1)) ? '0 : rd_ptr_r + AW'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   fill_r <= fill_r + (AW+1)'(1'b1);
                2'b01:   fill_r <= fill_r - (AW+1)'(1'b1);
                default: fill_r <= fill_r;
            endcase
        end
    end

    // Storage array; contents are not cleared by reset.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem[wr_ptr_r] <= push_data_i;
        end
    end

endmodule

// File: rtl/sienna_top.sv
// Single-lane inference pipeline: dot-product MAC, activation, max-pool and
// LFSR dropout, sequenced by one FSM; the MAC result crosses a FIFO into activation.
module sienna_top
    import sienna_pkg::*;
#(
    parameter int  N                         = 32,
    parameter int  DATA_WIDTH                = 32,
    parameter int  ADDR_LINES                = 5,
    parameter int  CONTROL_WIDTH             = 2,
    parameter int  POOL_H                    = 2,
    parameter int  POOL_W                    = 2,
    parameter real DROPOUT_P                 = 0.5,
    parameter int  LFSR_WIDTH                = 32,
    parameter int  INTERMEDIATE_BUFFER_DEPTH = 2 * N * N,
    parameter int  SRAM_DEPTH                = 1024,
    parameter int  IN_ROWS                   = 4,
    parameter int  IN_COLS                   = 4,
    parameter int  PADDING                   = 0,
    parameter      INPUT_A_FILE              = "input_a.hex",
    parameter      INPUT_B_FILE              = "input_b.hex"
)(
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         start_pipeline_i,
    input  logic [CONTROL_WIDTH-1:0]                     activation_function_i,
    input  logic [ADDR_LINES-1:0]                        num_terms_i,
    input  logic                                         north_write_enable_i,
    input  logic [DATA_WIDTH-1:0]                        north_write_data_i,
    input  logic                                         north_write_reset_i,
    input  logic                                         west_write_enable_i,
    input  logic [DATA_WIDTH-1:0]                        west_write_data_i,
    input  logic                                         west_write_reset_i,
    input  logic [DATA_WIDTH-1:0]                        maxpool_input_data_i,
    input  logic                                         maxpool_input_valid_i,
    output logic [DATA_WIDTH-1:0]                        final_result_o,
    output logic                                         pipeline_complete_o,
    output logic                                         gpnae_done_o,
    output logic                                         systolic_busy_o,
    output logic                                         gpnae_busy_o,
    output logic                                         maxpool_busy_o,
    output logic                                         dropout_busy_o,
    output logic                                         intermediate_buffer_full_o,
    output logic                                         intermediate_buffer_empty_o,
    output logic [DATA_WIDTH-1:0]                        systolic_result_debug_o,
    output logic                                         systolic_complete_debug_o,
    output logic [$clog2(INTERMEDIATE_BUFFER_DEPTH)-1:0] buffer_count_debug_o
);

    localparam int PTR_W      = $clog2(N + 1);
    localparam int IDX_W      = $clog2(N);
    localparam int POOL_CW    = $clog2(POOL_H * POOL_W + 1);
    localparam int DROP_LIMIT = (DROPOUT_P >= 1.0) ? 256 :
                                (DROPOUT_P <= 0.0) ? 0 : $rtoi(DROPOUT_P * 256.0);
    localparam logic [8:0]              DROP_LIMIT_W = 9'(DROP_LIMIT);
    localparam logic [POOL_CW-1:0]      POOL_WORDS   = POOL_CW'(POOL_H * POOL_W - 1);
    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'(32'sd32767);
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = DATA_WIDTH'(-32'sd32768);

    // Memory-image and geometry parameters are kept for drop-in compatibility only.
    if (SRAM_DEPTH < 32'sd0 || IN_ROWS < 32'sd0 || IN_COLS < 32'sd0 || PADDING < 32'sd0 ||
        $bits(INPUT_A_FILE) < 32'sd1 || $bits(INPUT_B_FILE) < 32'sd1) begin : g_unused_cfg
    end

    function automatic logic [DATA_WIDTH-1:0] activate(input logic [CONTROL_WIDTH-1:0] sel,
                                                       input logic [DATA_WIDTH-1:0]    x);
        logic neg;
        neg = x[DATA_WIDTH-1];
        case (sel)
            ACT_IDENTITY: return x;
            ACT_RELU:     return neg ? '0 : x;
            ACT_LEAKY:    return neg ? {{3{1'b1}}, x[DATA_WIDTH-1:3]} : x;
            ACT_SAT: begin
                if ($signed(x) > SAT_MAX) return SAT_MAX;
                else if ($signed(x) < SAT_MIN) return SAT_MIN;
                else return x;
            end
            default:      return x;
        endcase
    endfunction

    logic [DATA_WIDTH-1:0] north_mem [N];
    logic [DATA_WIDTH-1:0] west_mem  [N];
    logic [PTR_W-1:0]      north_ptr_r, west_ptr_r;
    logic                  north_wr_s, west_wr_s;

    state_t                state_r, next_state_s;
    logic [DATA_WIDTH-1:0] acc_r, value_r, final_r, sys_result_r, product_s;
    logic [ADDR_LINES-1:0] k_r, terms_r;
    logic [POOL_CW-1:0]    pool_cnt_r;
    logic [LFSR_WIDTH-1:0] lfsr_r;
    logic                  sys_complete_r, gpnae_done_r;
    logic                  mac_done_s, push_s, pop_s, pool_take_s, drop_s;
    logic [DATA_WIDTH-1:0] fifo_data_s;

    assign north_wr_s = north_write_enable_i && !north_write_reset_i && (north_ptr_r < PTR_W'(N));
    assign west_wr_s  = west_write_enable_i && !west_write_reset_i && (west_ptr_r < PTR_W'(N));

    // Load pointers: clear wins over write, writes stop once the buffer is full.
    always_ff @(posedge clk_i) begin
        if (rst_i || north_write_reset_i) north_ptr_r <= '0;
        else if (north_wr_s)              north_ptr_r <= north_ptr_r + PTR_W'(1'b1);
        if (rst_i || west_write_reset_i)  west_ptr_r  <= '0;
        else if (west_wr_s)               west_ptr_r  <= west_ptr_r + PTR_W'(1'b1);
    end

    // Operand buffer storage.
    always_ff @(posedge clk_i) begin
        if (north_wr_s) north_mem[north_ptr_r[IDX_W-1:0]] <= north_write_data_i;
        if (west_wr_s)  west_mem[west_ptr_r[IDX_W-1:0]]   <= west_write_data_i;
    end

    assign product_s   = north_mem[k_r] * west_mem[k_r];
    assign mac_done_s  = (k_r == terms_r);
    assign push_s      = (state_r == ST_MAC) && mac_done_s;
    assign pop_s       = (state_r == ST_ACT);
    assign pool_take_s = (state_r == ST_POOL) && (pool_cnt_r != POOL_WORDS) && maxpool_input_valid_i;
    assign drop_s      = ({1'b0, lfsr_r[7:0]} < DROP_LIMIT_W);

    sienna_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (INTERMEDIATE_BUFFER_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push_s),
        .push_data_i (acc_r),
        .pop_i       (pop_s),
        .pop_data_o  (fifo_data_s),
        .full_o      (intermediate_buffer_full_o),
        .empty_o     (intermediate_buffer_empty_o),
        .count_o     (buffer_count_debug_o)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_r <= ST_IDLE;
        else       state_r <= next_state_s;
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: if (start_pipeline_i) next_state_s = ST_MAC;  else next_state_s = ST_IDLE;
            ST_MAC:  if (mac_done_s)       next_state_s = ST_ACT;  else next_state_s = ST_MAC;
            ST_ACT:  next_state_s = ST_POOL;
            ST_POOL: if (pool_cnt_r == POOL_WORDS) next_state_s = ST_DROP; else next_state_s = ST_POOL;
            ST_DROP: next_state_s = ST_DONE;
            ST_DONE: if (!start_pipeline_i) next_state_s = ST_IDLE; else next_state_s = ST_DONE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Datapath: accumulate, activate, pool, drop and capture the result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_r          <= '0;
            k_r            <= '0;
            terms_r        <= '0;
            value_r        <= '0;
            pool_cnt_r     <= '0;
            final_r        <= '0;
            sys_result_r   <= '0;
            sys_complete_r <= 1'b0;
            gpnae_done_r   <= 1'b0;
            lfsr_r         <= LFSR_WIDTH'(LFSR_SEED);
        end else begin
            sys_complete_r <= 1'b0;
            gpnae_done_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_pipeline_i) begin
                        acc_r   <= '0;
                        k_r     <= '0;
                        terms_r <= num_terms_i;
                    end
                end
                ST_MAC: begin
                    if (mac_done_s) begin
                        sys_result_r   <= acc_r;
                        sys_complete_r <= 1'b1;
                    end else begin
                        acc_r <= acc_r + product_s;
                        k_r   <= k_r + ADDR_LINES'(1'b1);
                    end
                end
                ST_ACT: begin
                    value_r      <= activate(activation_function_i, fifo_data_s);
                    gpnae_done_r <= 1'b1;
                    pool_cnt_r   <= '0;
                end
                ST_POOL: begin
                    if (pool_take_s) begin
                        pool_cnt_r <= pool_cnt_r + POOL_CW'(1'b1);
                        if ($signed(maxpool_input_data_i) > $signed(value_r)) value_r <= maxpool_input_data_i;
                    end
                end
                ST_DROP: begin
                    lfsr_r  <= LFSR_WIDTH'(lfsr_step(32'(lfsr_r)));
                    final_r <= drop_s ? '0 : value_r;
                end
                default: ;
            endcase
        end
    end

    assign final_result_o            = final_r;
    assign systolic_result_debug_o   = sys_result_r;
    assign systolic_complete_debug_o = sys_complete_r;
    assign gpnae_done_o              = gpnae_done_r;
    assign pipeline_complete_o       = (state_r == ST_DONE);
    assign systolic_busy_o           = (state_r == ST_MAC);
    assign gpnae_busy_o              = (state_r == ST_ACT);
    assign maxpool_busy_o            = (state_r == ST_POOL);
    assign dropout_busy_o            = (state_r == ST_DROP);

endmodule

// File: tb/tb_sienna_top.sv
// Bench for sienna_top: a directed vector table, hand-written sequences and
// random runs checked against an arithmetic model; a second instance always drops.
module tb_sienna_top;

    localparam logic [31:0] MINV = 32'h80000000;

    logic        clk = 1'b0;
    logic        rst_i, start_pipeline_i;
    logic [1:0]  activation_function_i;
    logic [4:0]  num_terms_i;
    logic        north_write_enable_i, north_write_reset_i, west_write_enable_i, west_write_reset_i;
    logic [31:0] north_write_data_i, west_write_data_i, maxpool_input_data_i;
    logic        maxpool_input_valid_i;

    logic [31:0] final_result_o, systolic_result_debug_o;
    logic        pipeline_complete_o, gpnae_done_o, systolic_busy_o, gpnae_busy_o, maxpool_busy_o;
    logic        dropout_busy_o, intermediate_buffer_full_o, intermediate_buffer_empty_o, systolic_complete_debug_o;
    logic [10:0] buffer_count_debug_o;

    logic [31:0] p1_final, p1_dbg;
    logic        p1_complete, p1_gdone, p1_sbusy, p1_gbusy, p1_mbusy, p1_dbusy, p1_full, p1_empty, p1_scomp;
    logic [10:0] p1_count;

    always #5 clk = ~clk;

    sienna_top #(.DROPOUT_P(0.0)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_pipeline_i(start_pipeline_i),
        .activation_function_i(activation_function_i), .num_terms_i(num_terms_i),
        .north_write_enable_i(north_write_enable_i), .north_write_data_i(north_write_data_i),
        .north_write_reset_i(north_write_reset_i), .west_write_enable_i(west_write_enable_i),
        .west_write_data_i(west_write_data_i), .west_write_reset_i(west_write_reset_i),
        .maxpool_input_data_i(maxpool_input_data_i), .maxpool_input_valid_i(maxpool_input_valid_i),
        .final_result_o(final_result_o), .pipeline_complete_o(pipeline_complete_o),
        .gpnae_done_o(gpnae_done_o), .systolic_busy_o(systolic_busy_o), .gpnae_busy_o(gpnae_busy_o),
        .maxpool_busy_o(maxpool_busy_o), .dropout_busy_o(dropout_busy_o),
        .intermediate_buffer_full_o(intermediate_buffer_full_o),
        .intermediate_buffer_empty_o(intermediate_buffer_empty_o),
        .systolic_result_debug_o(systolic_result_debug_o),
        .systolic_complete_debug_o(systolic_complete_debug_o),
        .buffer_count_debug_o(buffer_count_debug_o)
    );

    sienna_top #(.DROPOUT_P(1.0)) dut_p1 (
        .clk_i(clk), .rst_i(rst_i), .start_pipeline_i(start_pipeline_i),
        .activation_function_i(activation_function_i), .num_terms_i(num_terms_i),
        .north_write_enable_i(north_write_enable_i), .north_write_data_i(north_write_data_i),
        .north_write_reset_i(north_write_reset_i), .west_write_enable_i(west_write_enable_i),
        .west_write_data_i(west_write_data_i), .west_write_reset_i(west_write_reset_i),
        .maxpool_input_data_i(maxpool_input_data_i), .maxpool_input_valid_i(maxpool_input_valid_i),
        .final_result_o(p1_final), .pipeline_complete_o(p1_complete), .gpnae_done_o(p1_gdone),
        .systolic_busy_o(p1_sbusy), .gpnae_busy_o(p1_gbusy), .maxpool_busy_o(p1_mbusy),
        .dropout_busy_o(p1_dbusy), .intermediate_buffer_full_o(p1_full),
        .intermediate_buffer_empty_o(p1_empty), .systolic_result_debug_o(p1_dbg),
        .systolic_complete_debug_o(p1_scomp), .buffer_count_debug_o(p1_count)
    );

    int tests = 0;
    int fails = 0;
    int mac_c, sc_c, gd_c, cnt_max;
    logic [31:0] tb_n [32];
    logic [31:0] tb_w [32];

    typedef struct {
        logic [31:0] nb, ns, wv;
        int          terms, act;
        logic [31:0] p0, p1, p2, exp_dbg, exp_fin;
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic sample_flags();
        if (systolic_busy_o) mac_c++;
        if (systolic_complete_debug_o) sc_c++;
        if (gpnae_done_o) gd_c++;
        if (int'(buffer_count_debug_o) > cnt_max) cnt_max = int'(buffer_count_debug_o);
    endtask

    // Reference: dot product with 32-bit wrap, activation, signed max, no drop.
    function automatic int model(input int terms, input int act, input int p0, input int p1, input int p2);
        int s = 0;
        int v;
        for (int k = 0; k < terms; k++) s += int'(tb_n[k]) * int'(tb_w[k]);
        if (act == 1)      v = (s < 0) ? 0 : s;
        else if (act == 2) v = (s < 0) ? (s >>> 3) : s;
        else if (act == 3) v = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
        else               v = s;
        if (p0 > v) v = p0;
        if (p1 > v) v = p1;
        if (p2 > v) v = p2;
        return v;
    endfunction

    task automatic load_buffers();
        north_write_reset_i = 1'b1; west_write_reset_i = 1'b1;
        @(negedge clk);
        north_write_reset_i = 1'b0; west_write_reset_i = 1'b0;
        for (int k = 0; k < 33; k++) begin
            north_write_enable_i = 1'b1; west_write_enable_i = 1'b1;
            north_write_data_i = (k < 32) ? tb_n[k] : 32'hDEADBEEF;
            west_write_data_i  = (k < 32) ? tb_w[k] : 32'h0BADF00D;
            @(negedge clk);
        end
        north_write_enable_i = 1'b0; west_write_enable_i = 1'b0;
    endtask

    task automatic run_pipeline(input string name, input int terms, input int act,
                                input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                                input logic [31:0] exp_dbg, input logic [31:0] exp_fin,
                                input bit hold, input bit restart);
        int cyc;
        logic [31:0] pw [3];
        pw[0] = p0; pw[1] = p1; pw[2] = p2;
        mac_c = 0; sc_c = 0; gd_c = 0; cnt_max = 0;
        num_terms_i = 5'(terms);
        activation_function_i = 2'(act);
        maxpool_input_valid_i = 1'b1;
        maxpool_input_data_i = 32'h7FFFFFFF;
        start_pipeline_i = 1'b1;
        @(negedge clk);
        if (!hold) start_pipeline_i = 1'b0;
        cyc = 0;
        while (cyc < 200) begin
            sample_flags();
            if (maxpool_busy_o) break;
            if (restart && cyc == 3) start_pipeline_i = 1'b1;
            if (restart && cyc == 4 && !hold) start_pipeline_i = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check({name, "_pool_reached"}, {31'd0, maxpool_busy_o}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            maxpool_input_valid_i = (i != 2);
            maxpool_input_data_i = (i == 2) ? 32'h7FFFFFFF : pw[(i < 2) ? i : 2];
            @(negedge clk);
            sample_flags();
        end
        maxpool_input_valid_i = 1'b0;
        cyc = 0;
        while (!pipeline_complete_o && cyc < 50) begin
            @(negedge clk);
            sample_flags();
            cyc++;
        end
        check({name, "_complete"}, {31'd0, pipeline_complete_o}, 32'd1);
        check({name, "_debug"}, systolic_result_debug_o, exp_dbg);
        check({name, "_final"}, final_result_o, exp_fin);
        check({name, "_drop_all"}, {p1_final[31:1], p1_complete ^ p1_final[0]}, 32'd1);
        check({name, "_mac_cycles"}, 32'(mac_c), 32'(terms + 1));
        check({name, "_pulses"}, {24'd0, 4'(sc_c), 4'(gd_c)}, 32'h11);
        check({name, "_fifo_peak"}, 32'(cnt_max), 32'd1);
        if (hold) begin
            repeat (3) @(negedge clk);
            check({name, "_hold_complete"}, {31'd0, pipeline_complete_o}, 32'd1);
            start_pipeline_i = 1'b0;
        end
        @(negedge clk);
        check({name, "_back_idle"}, {30'd0, pipeline_complete_o, intermediate_buffer_empty_o}, 32'd1);
        check({name, "_final_hold"}, final_result_o, exp_fin);
    endtask

    task automatic fill_pattern(input logic [31:0] nb, input logic [31:0] ns, input logic [31:0] wv);
        for (int k = 0; k < 32; k++) begin
            tb_n[k] = nb + 32'(k) * ns;
            tb_w[k] = wv;
        end
    endtask

    initial begin
        vecs[0] = '{32'd1, 32'd1, 32'd1, 16, 0, 32'd0, 32'd0, 32'd0, 32'h88, 32'h88};
        vecs[1] = '{32'hFFFFFFFB, 32'd0, 32'd3, 1, 1, MINV, MINV, MINV, 32'hFFFFFFF1, 32'h0};
        vecs[2] = '{32'hFFFFFFFB, 32'd0, 32'd3, 1, 2, MINV, MINV, MINV, 32'hFFFFFFF1, 32'hFFFFFFFE};
        vecs[3] = '{32'd10, 32'd0, 32'd1, 1, 0, 32'd5, 32'd20, 32'd7, 32'hA, 32'h14};
        vecs[4] = '{32'd5, 32'd1, 32'd7, 0, 0, MINV, MINV, MINV, 32'h0, 32'h0};
        vecs[5] = '{32'd1000, 32'd0, 32'd1000, 1, 3, MINV, MINV, MINV, 32'h000F4240, 32'h00007FFF};
        vecs[6] = '{32'hFFFFFC18, 32'd0, 32'd1000, 1, 3, MINV, MINV, MINV, 32'hFFF0BDC0, 32'hFFFF8000};
        vecs[7] = '{32'h7FFFFFFF, 32'd0, 32'd2, 1, 0, MINV, MINV, MINV, 32'hFFFFFFFE, 32'hFFFFFFFE};
        vecs[8] = '{32'd0, 32'd1, 32'd2, 31, 3, MINV, MINV, MINV, 32'h3A2, 32'h3A2};
        vecs[9] = '{32'd3, 32'd0, 32'd4, 2, 1, 32'h30, 32'hFFFFFFFF, 32'd2, 32'h18, 32'h30};

        rst_i = 1'b1; start_pipeline_i = 1'b0; activation_function_i = 2'd0; num_terms_i = 5'd0;
        north_write_enable_i = 1'b0; north_write_reset_i = 1'b0; north_write_data_i = 32'd0;
        west_write_enable_i = 1'b0; west_write_reset_i = 1'b0; west_write_data_i = 32'd0;
        maxpool_input_data_i = 32'd0; maxpool_input_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        check("reset_flags", {23'd0, pipeline_complete_o, gpnae_done_o, systolic_busy_o, gpnae_busy_o,
              maxpool_busy_o, dropout_busy_o, intermediate_buffer_full_o, intermediate_buffer_empty_o,
              systolic_complete_debug_o}, 32'h2);
        check("reset_count", {21'd0, buffer_count_debug_o}, 32'd0);
        check("reset_final", final_result_o, 32'd0);
        check("reset_debug", systolic_result_debug_o, 32'd0);

        for (int i = 0; i < 10; i++) begin
            fill_pattern(vecs[i].nb, vecs[i].ns, vecs[i].wv);
            load_buffers();
            run_pipeline($sformatf("vec%0d", i), vecs[i].terms, vecs[i].act, vecs[i].p0, vecs[i].p1,
                         vecs[i].p2, vecs[i].exp_dbg, vecs[i].exp_fin, 1'b0, 1'b0);
        end

        // Start held high through the run, and a second start pulse mid-MAC.
        fill_pattern(32'd1, 32'd1, 32'd1);
        load_buffers();
        run_pipeline("hold", 16, 0, 32'd0, 32'd0, 32'd0, 32'h88, 32'h88, 1'b1, 1'b0);
        run_pipeline("restart", 16, 0, 32'd0, 32'd0, 32'd0, 32'h88, 32'h88, 1'b0, 1'b1);

        // Write-reset must win over a simultaneous write enable.
        north_write_reset_i = 1'b1; west_write_reset_i = 1'b1;
        north_write_enable_i = 1'b1; west_write_enable_i = 1'b1;
        north_write_data_i = 32'd99; west_write_data_i = 32'd99;
        @(negedge clk);
        north_write_reset_i = 1'b0; west_write_reset_i = 1'b0;
        north_write_data_i = 32'd7; west_write_data_i = 32'd1;
        @(negedge clk);
        north_write_enable_i = 1'b0; west_write_enable_i = 1'b0;
        run_pipeline("reset_priority", 1, 0, MINV, MINV, MINV, 32'd7, 32'd7, 1'b0, 1'b0);

        for (int r = 0; r < 30; r++) begin
            int terms, act, p0, p1, p2, exp_v;
            for (int k = 0; k < 32; k++) begin
                tb_n[k] = ($urandom_range(0, 3) == 0) ? $urandom : 32'(int'($urandom_range(0, 400)) - 200);
                tb_w[k] = ($urandom_range(0, 3) == 0) ? $urandom : 32'(int'($urandom_range(0, 400)) - 200);
            end
            terms = int'($urandom_range(0, 31));
            act   = int'($urandom_range(0, 3));
            p0 = ($urandom_range(0, 4) == 0) ? int'($urandom) : int'($urandom_range(0, 600)) - 300;
            p1 = int'($urandom_range(0, 600)) - 300;
            p2 = ($urandom_range(0, 1) == 0) ? int'(MINV) : int'($urandom_range(0, 600)) - 300;
            exp_v = model(terms, act, p0, p1, p2);
            load_buffers();
            run_pipeline($sformatf("rand%0d", r), terms, act, 32'(p0), 32'(p1), 32'(p2),
                         32'(model(terms, 0, int'(MINV), int'(MINV), int'(MINV))), 32'(exp_v), 1'b0, 1'b0);
        end

        // Reset during MAC aborts the run without completion.
        fill_pattern(32'd1, 32'd1, 32'd1);
        load_buffers();
        num_terms_i = 5'd16;
        start_pipeline_i = 1'b1;
        @(negedge clk);
        start_pipeline_i = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_abort_busy", {31'd0, systolic_busy_o}, 32'd1);
        rst_i = 1'b1;
        @(negedge clk);
        check("abort_flags", {25'd0, systolic_busy_o, gpnae_busy_o, maxpool_busy_o, dropout_busy_o,
              pipeline_complete_o, intermediate_buffer_full_o, intermediate_buffer_empty_o}, 32'h1);
        check("abort_count", {21'd0, buffer_count_debug_o}, 32'd0);
        rst_i = 1'b0;
        sc_c = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (pipeline_complete_o || systolic_complete_debug_o) sc_c++;
        end
        check("abort_no_complete", 32'(sc_c), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sienna_top.md
SIENNA_TOP -- requirements
Module: sienna_top

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameters SHALL be, as name, default, meaning: N 32 input-buffer depth; DATA_WIDTH 32 word width; ADDR_LINES 5 num_terms width; CONTROL_WIDTH 2 activation-select width; POOL_H 2 and POOL_W 2 pool window; DROPOUT_P 0.5 drop probability (real); LFSR_WIDTH 32; INTERMEDIATE_BUFFER_DEPTH 2*N*N FIFO depth.
REQ-003 SRAM_DEPTH, IN_ROWS, IN_COLS, PADDING, INPUT_A_FILE and INPUT_B_FILE SHALL be accepted and SHALL have no functional effect.
REQ-004 Ports SHALL be, as name, direction, width, meaning: clk_i in 1 clock; rst_i in 1 sync active-high reset.
REQ-005 Control ports: start_pipeline_i in 1 start; activation_function_i in CONTROL_WIDTH activation select; num_terms_i in ADDR_LINES MAC length.
REQ-006 North and west load ports: north_write_enable_i/north_write_data_i/north_write_reset_i in 1/DATA_WIDTH/1; west_* SHALL be identical.
REQ-007 Maxpool ports: maxpool_input_data_i in DATA_WIDTH; maxpool_input_valid_i in 1.
REQ-008 Result ports: final_result_o out DATA_WIDTH; pipeline_complete_o out 1; gpnae_done_o out 1.
REQ-009 Status ports: systolic_busy_o, gpnae_busy_o, maxpool_busy_o, dropout_busy_o, intermediate_buffer_full_o and intermediate_buffer_empty_o SHALL each be 1-bit outputs.
REQ-010 Debug ports: systolic_result_debug_o out DATA_WIDTH; systolic_complete_debug_o out 1; buffer_count_debug_o out $clog2(INTERMEDIATE_BUFFER_DEPTH).

Function
REQ-011 North and west buffers SHALL be N words each; *_write_reset_i SHALL clear the write pointer; *_write_enable_i SHALL write data at the pointer and increment it; writes with pointer==N SHALL be ignored; reset priority SHALL win over enable.
REQ-012 FSM states SHALL be IDLE, MAC, ACT, POOL, DROP, DONE.
REQ-013 IDLE->MAC SHALL occur when start_pipeline_i is sampled high; start_pipeline_i in any other state SHALL be ignored.
REQ-014 MAC SHALL accumulate north[k]*west[k] for k=0..num_terms_i-1, one term per cycle, with signed DATA_WIDTH wrap-around; num_terms_i=0 SHALL yield 0 after one cycle; systolic_busy_o SHALL be high in MAC.
REQ-015 On MAC end, the accumulator SHALL be registered to systolic_result_debug_o, SHALL be pushed into the intermediate FIFO, and systolic_complete_debug_o SHALL pulse for 1 cycle.
REQ-016 ACT SHALL take 1 cycle, pop the FIFO and apply, by activation_function_i (signed): 00 identity; 01 ReLU (negative->0); 10 leaky (negative>>>3); 11 saturate to [-32768,32767].
REQ-017 gpnae_busy_o SHALL be high in ACT; gpnae_done_o SHALL pulse 1 cycle on ACT exit.
REQ-018 POOL SHALL hold maxpool_busy_o high and accept POOL_H*POOL_W-1 words on maxpool_input_valid_i; result SHALL be the signed max of the activated value and those words; valid outside POOL SHALL be ignored.
REQ-019 DROP SHALL take 1 cycle with dropout_busy_o high and advance the LFSR once; value SHALL be forced to 0 when lfsr[7:0] < floor(DROPOUT_P*256), else passed unchanged; DROPOUT_P>=1.0 SHALL always drop.
REQ-020 DONE SHALL register final_result_o and hold pipeline_complete_o high until start_pipeline_i is low, then return to IDLE; final_result_o SHALL hold until the next DONE.
REQ-021 The FIFO SHALL be synchronous with full/empty flags; a push when full SHALL be dropped; a pop when empty SHALL return 0.
REQ-022 The FIFO count SHALL wrap to 0 at full, with the full flag high.

Reset
REQ-023 rst_i SHALL force IDLE, all outputs 0 except intermediate_buffer_empty_o=1, FIFO and load pointers 0, and LFSR = 32'hACE1ACE1; buffer contents need not clear.
REQ-024 rst_i mid-operation SHALL abort the run with no pipeline_complete_o.

Structure
REQ-025 Package sienna_pkg SHALL hold the state enum, activation codes, LFSR seed and the Galois polynomial 32'h80200003.
REQ-026 The intermediate FIFO SHALL be sub-module sienna_fifo; all else SHALL be inline.

Verification
REQ-027 north=1..16, west all 1, terms=16, act=00, pool inputs 0,0,0, DROPOUT_P=0 -> systolic_result_debug_o=0x88 and final_result_o=0x88.
REQ-028 north[0]=0xFFFFFFFB, west[0]=3, terms=1, act=01 -> debug=0xFFFFFFF1 and final=0; with act=10 -> final=0xFFFFFFFE.
REQ-029 MAC result 10, act=00, pool inputs 5,20,7 -> final=0x14; valid pulses before POOL SHALL have no effect.
REQ-030 terms=0 -> final=0; a second start during MAC SHALL not restart it; DROPOUT_P=1.0 -> final=0.
REQ-031 rst_i asserted in MAC -> next cycle all busy flags 0, empty=1, count=0, and no completion.
